// File: rtl/conv_pe_scheduler_pkg.sv
// Shared types and width helpers for the convolution PE scheduler.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KLOAD  = 3'd1,
        S_KDRAIN = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } sched_state_e;

    localparam int unsigned DEF_KERNEL_SIZE       = 3;
    localparam int unsigned DEF_CHANNELS          = 3;
    localparam int unsigned DEF_KERNEL_DATA_WIDTH = 8;
    localparam int unsigned KE          = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE * DEF_CHANNELS;
    localparam int unsigned KERNEL_BITS = KE * DEF_KERNEL_DATA_WIDTH;

    function automatic int unsigned ke_f(input int unsigned ks, input int unsigned ch);
        return ks * ks * ch;
    endfunction

    // Width of a counter/address covering 0..n-1, never below one bit.
    function automatic int unsigned clog2w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_pe_scheduler_if.sv
// Kernel and pixel BRAM read ports driven by the scheduler.
interface conv_pe_scheduler_if #(
    parameter int unsigned NUM_PE = 3,
    parameter int unsigned KDW    = 8,
    parameter int unsigned IDW    = 8,
    parameter int unsigned KA_W   = 5,
    parameter int unsigned PIX_AW = 15
);
    logic                    kbram_en;
    logic [KA_W-1:0]         kbram_addr;
    logic [NUM_PE*KDW-1:0]   kbram_dout;
    logic                    pbram_en;
    logic [PIX_AW-1:0]       pbram_addr;
    logic [IDW-1:0]          pbram_dout;

    modport master (
        output kbram_en, kbram_addr, pbram_en, pbram_addr,
        input  kbram_dout, pbram_dout
    );

    modport slave (
        input  kbram_en, kbram_addr, pbram_en, pbram_addr,
        output kbram_dout, pbram_dout
    );
endinterface

// File: rtl/conv_pe_scheduler_rd_pipe.sv
// Read-valid shift register: flags the cycle a BRAM read issued RD_LATENCY cycles ago returns data.
module bram_rd_pipe #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue_i,
    output logic cap_o
);
    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] vld_d;

    generate
        if (RD_LATENCY == 1) begin : g_one
            assign vld_d = issue_i;
        end else begin : g_multi
            assign vld_d = {vld_q[RD_LATENCY-2:0], issue_i};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    assign cap_o = vld_q[RD_LATENCY-1];
endmodule

// File: rtl/conv_pe_scheduler.sv
// Sequencer for the 3-PE convolution datapath: kernel load, pixel streaming, tile accounting.
// Optional SCHED_PERF_CNT_EN adds stream/hold cycle counters.
module conv_pe_scheduler
    import conv_sched_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE       = 3,
    parameter int unsigned CHANNELS          = 3,
    parameter int unsigned KERNEL_DATA_WIDTH = 8,
    parameter int unsigned INPUT_DATA_WIDTH  = 8,
    parameter int unsigned NUM_PE            = 3,
    parameter int unsigned IMG_PIXELS        = 300,
    parameter int unsigned NUM_TILES         = 16,
    parameter int unsigned PIX_ADDR_WIDTH    = 15,
    parameter int unsigned RD_LATENCY        = 1
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   i_start,
    input  logic                                   i_stream_hold,
    conv_pe_scheduler_if.master                    bram_if,
    output logic [INPUT_DATA_WIDTH-1:0]            o_pixel_data,
    output logic                                   o_pixel_valid,
    output logic [NUM_PE*ke_f(KERNEL_SIZE, CHANNELS)*KERNEL_DATA_WIDTH-1:0] o_kernel,
    output logic                                   o_kernel_valid,
    input  logic [NUM_PE-1:0]                      i_final_flatten,
    output logic                                   o_proc_finish,
    output logic [clog2w(NUM_TILES+1)-1:0]         o_tile_count,
    output logic                                   o_busy,
`ifdef SCHED_PERF_CNT_EN
    output logic [31:0]                            o_run_cycles,
    output logic [31:0]                            o_hold_cycles,
`endif
    output logic                                   o_done
);
    localparam int unsigned KE_N    = ke_f(KERNEL_SIZE, CHANNELS);
    localparam int unsigned KBITS_N = KE_N * KERNEL_DATA_WIDTH;
    localparam int unsigned KA_W    = clog2w(KE_N);
    localparam int unsigned KC_W    = clog2w(KE_N + 1);
    localparam int unsigned PC_W    = clog2w(IMG_PIXELS + 1);
    localparam int unsigned TC_W    = clog2w(NUM_TILES + 1);

    sched_state_e               state_q, state_d;
    logic                       kbram_en_q, kbram_en_d;
    logic [KA_W-1:0]            kbram_addr_q, kbram_addr_d;
    logic [KC_W-1:0]            kcap_cnt_q, kcap_cnt_d;
    logic [NUM_PE*KBITS_N-1:0]  kernel_q, kernel_d;
    logic                       kernel_valid_q, kernel_valid_d;
    logic                       pbram_en_q, pbram_en_d;
    logic [PIX_ADDR_WIDTH-1:0]  pbram_addr_q, pbram_addr_d;
    logic [PC_W-1:0]            iss_cnt_q, iss_cnt_d;
    logic [PC_W-1:0]            dlv_cnt_q, dlv_cnt_d;
    logic [INPUT_DATA_WIDTH-1:0] pix_data_q, pix_data_d;
    logic                       pix_valid_q, pix_valid_d;
    logic [NUM_PE-1:0]          flags_q, flags_d;
    logic                       proc_finish_q, proc_finish_d;
    logic [TC_W-1:0]            tile_cnt_q, tile_cnt_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       kcap, pcap, start_run, tile_fire;

    bram_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_kpipe (
        .clk(clk), .rst_n(reset_n), .issue_i(kbram_en_q), .cap_o(kcap)
    );

    bram_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_ppipe (
        .clk(clk), .rst_n(reset_n), .issue_i(pbram_en_q), .cap_o(pcap)
    );

    assign start_run = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign tile_fire = (&flags_q) && (tile_cnt_q < TC_W'(NUM_TILES));

    always_comb begin
        state_d        = state_q;
        kbram_en_d     = 1'b0;
        kbram_addr_d   = kbram_addr_q;
        kcap_cnt_d     = kcap_cnt_q;
        kernel_d       = kernel_q;
        kernel_valid_d = kernel_valid_q;
        pbram_en_d     = 1'b0;
        pbram_addr_d   = pbram_addr_q;
        iss_cnt_d      = iss_cnt_q;
        dlv_cnt_d      = dlv_cnt_q;
        pix_data_d     = pix_data_q;
        pix_valid_d    = pcap;
        flags_d        = flags_q;
        proc_finish_d  = 1'b0;
        tile_cnt_d     = tile_cnt_q;

        // Address-0 element shifts up to the MSBs of each PE's kernel word.
        if (kcap) begin
            for (int p = 0; p < int'(NUM_PE); p++) begin
                kernel_d[p*KBITS_N +: KBITS_N] =
                    {kernel_q[p*KBITS_N +: KBITS_N-KERNEL_DATA_WIDTH],
                     bram_if.kbram_dout[p*KERNEL_DATA_WIDTH +: KERNEL_DATA_WIDTH]};
            end
            kcap_cnt_d = kcap_cnt_q + KC_W'(1);
        end
        if (pcap) begin
            pix_data_d = bram_if.pbram_dout;
            dlv_cnt_d  = dlv_cnt_q + PC_W'(1);
        end

        // A flatten bit landing on the clearing edge survives into the next tile.
        if (tile_fire) begin
            proc_finish_d = 1'b1;
            tile_cnt_d    = tile_cnt_q + TC_W'(1);
            flags_d       = '0;
        end
        if (kernel_valid_q && (tile_cnt_d < TC_W'(NUM_TILES)))
            flags_d = flags_d | i_final_flatten;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_run) begin
                    state_d        = S_KLOAD;
                    kbram_en_d     = 1'b1;
                    kbram_addr_d   = '0;
                    kcap_cnt_d     = '0;
                    kernel_valid_d = 1'b0;
                    tile_cnt_d     = '0;
                    flags_d        = '0;
                    iss_cnt_d      = '0;
                    dlv_cnt_d      = '0;
                    pbram_addr_d   = '0;
                end
            end
            S_KLOAD: begin
                if (kbram_addr_q == KA_W'(KE_N - 1)) begin
                    state_d = S_KDRAIN;
                end else begin
                    kbram_en_d   = 1'b1;
                    kbram_addr_d = kbram_addr_q + KA_W'(1);
                end
            end
            S_KDRAIN: begin
                if (kcap && (kcap_cnt_q == KC_W'(KE_N - 1))) begin
                    kernel_valid_d = 1'b1;
                    state_d        = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!i_stream_hold && (iss_cnt_q < PC_W'(IMG_PIXELS))) begin
                    pbram_en_d   = 1'b1;
                    pbram_addr_d = PIX_ADDR_WIDTH'(iss_cnt_q);
                    iss_cnt_d    = iss_cnt_q + PC_W'(1);
                end
                if ((tile_cnt_q == TC_W'(NUM_TILES)) && (dlv_cnt_q == PC_W'(IMG_PIXELS)))
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_KLOAD) || (state_d == S_KDRAIN) || (state_d == S_STREAM);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            kbram_en_q     <= 1'b0;
            kbram_addr_q   <= '0;
            kcap_cnt_q     <= '0;
            kernel_q       <= '0;
            kernel_valid_q <= 1'b0;
            pbram_en_q     <= 1'b0;
            pbram_addr_q   <= '0;
            iss_cnt_q      <= '0;
            dlv_cnt_q      <= '0;
            pix_data_q     <= '0;
            pix_valid_q    <= 1'b0;
            flags_q        <= '0;
            proc_finish_q  <= 1'b0;
            tile_cnt_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            kbram_en_q     <= kbram_en_d;
            kbram_addr_q   <= kbram_addr_d;
            kcap_cnt_q     <= kcap_cnt_d;
            kernel_q       <= kernel_d;
            kernel_valid_q <= kernel_valid_d;
            pbram_en_q     <= pbram_en_d;
            pbram_addr_q   <= pbram_addr_d;
            iss_cnt_q      <= iss_cnt_d;
            dlv_cnt_q      <= dlv_cnt_d;
            pix_data_q     <= pix_data_d;
            pix_valid_q    <= pix_valid_d;
            flags_q        <= flags_d;
            proc_finish_q  <= proc_finish_d;
            tile_cnt_q     <= tile_cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] run_cyc_q;
    logic [31:0] hold_cyc_q;

    // Saturating counters, restarted at each run's kernel load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_cyc_q  <= '0;
            hold_cyc_q <= '0;
        end else if (start_run) begin
            run_cyc_q  <= '0;
            hold_cyc_q <= '0;
        end else if (state_q == S_STREAM) begin
            if (run_cyc_q != '1) run_cyc_q <= run_cyc_q + 32'(1);
            if (i_stream_hold && (iss_cnt_q < PC_W'(IMG_PIXELS)) && (hold_cyc_q != '1))
                hold_cyc_q <= hold_cyc_q + 32'(1);
        end
    end

    assign o_run_cycles  = run_cyc_q;
    assign o_hold_cycles = hold_cyc_q;
`else
    // Performance counters compiled out.
`endif

    assign bram_if.kbram_en   = kbram_en_q;
    assign bram_if.kbram_addr = kbram_addr_q;
    assign bram_if.pbram_en   = pbram_en_q;
    assign bram_if.pbram_addr = pbram_addr_q;
    assign o_pixel_data       = pix_data_q;
    assign o_pixel_valid      = pix_valid_q;
    assign o_kernel           = kernel_q;
    assign o_kernel_valid     = kernel_valid_q;
    assign o_proc_finish      = proc_finish_q;
    assign o_tile_count       = tile_cnt_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;
endmodule

// File: doc/conv_pe_scheduler.md
Name: conv_pe_scheduler

Overview:
Top-level sequencer for the 3-PE convolution datapath.
- Loads all NUM_PE kernels from their kernel BRAMs.
- Streams image pixels from the input BRAM into the input control unit, honouring read latency.
- Aggregates per-PE finalFlatten into the single proc_finish pulse and counts tiles to completion.
- Replaces the ad-hoc read and kernel-load always blocks in the top level.

Parameters:
KERNEL_SIZE, 3, kernel edge length
CHANNELS, 3, input channels
KERNEL_DATA_WIDTH, 8, kernel element width
INPUT_DATA_WIDTH, 8, pixel width
NUM_PE, 3, PEs (and kernel BRAMs) driven
IMG_PIXELS, 300, pixels streamed per run (W*W*CHANNELS)
NUM_TILES, 16, tiles per run; run ends after this many proc_finish pulses
PIX_ADDR_WIDTH, 15, pixel BRAM address width
RD_LATENCY, 1, BRAM read latency in cycles (1..3), common to all BRAMs

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_start  in  1  1-cycle run request; honoured only in IDLE or DONE
i_stream_hold  in  1  freezes new pixel address issue; in-flight reads still deliver
o_kbram_en  out  1  kernel BRAM enable (shared)
o_kbram_addr  out  $clog2(KE)  kernel BRAM address, KE = KERNEL_SIZE^2*CHANNELS
i_kbram_dout  in  NUM_PE*KERNEL_DATA_WIDTH  PE p's data at slice p
o_pbram_en  out  1  pixel BRAM enable
o_pbram_addr  out  PIX_ADDR_WIDTH  pixel BRAM address
i_pbram_dout  in  INPUT_DATA_WIDTH  pixel BRAM data
o_pixel_data  out  INPUT_DATA_WIDTH  to input control unit
o_pixel_valid  out  1  pixel qualifier
o_kernel  out  NUM_PE*KE*KERNEL_DATA_WIDTH  kernels; PE p at slice p
o_kernel_valid  out  1  kernels stable and loaded
i_final_flatten  in  NUM_PE  per-PE tile-complete pulses
o_proc_finish  out  1  1-cycle pulse: all PEs finished current tile
o_tile_count  out  $clog2(NUM_TILES+1)  completed tiles
o_busy  out  1  high in KLOAD/KDRAIN/STREAM
o_done  out  1  high in DONE

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0, o_kernel included; sticky flags, counters and read-valid pipeline cleared. Reset mid-run aborts with no residual pulses.

States:
- IDLE: i_start -> KLOAD.
- KLOAD: o_kbram_en=1; o_kbram_addr 0..KE-1, one per cycle. Cycle after addr KE-1 is issued -> KDRAIN.
- KDRAIN: wait until KE captures are done. Then o_kernel_valid=1 (held until reset or a new run) -> STREAM.
- STREAM: pixel issue plus tile accounting. When o_tile_count==NUM_TILES and all IMG_PIXELS are delivered -> DONE.
- DONE: o_done=1. i_start -> KLOAD; this clears o_kernel_valid and o_tile_count.

Kernel and pixel reads:
- Each issued kernel or pixel read pushes a valid bit into a RD_LATENCY-deep shift register; data is captured when the bit emerges.
- Kernel capture: each PE's register shifts left by KERNEL_DATA_WIDTH and the new byte enters the LSBs. The address-0 element ends in the MSBs.
- Pixel issue: o_pbram_en=1 and the address increments each cycle while !i_stream_hold and fewer than IMG_PIXELS have been issued. With i_stream_hold, the address is held and en=0.
- o_pixel_data/o_pixel_valid are registered. Latency from address issue = RD_LATENCY+1 cycles. No gaps except hold-induced ones.
- No addresses are issued past IMG_PIXELS-1, so the address never wraps.

Tile accounting:
- i_final_flatten bits set per-PE sticky flags. This happens only while o_kernel_valid; bits arriving earlier are ignored.
- When all NUM_PE flags are set (registered), o_proc_finish pulses the next cycle, flags clear and o_tile_count increments.
- A flatten bit arriving on the clearing edge is kept for the next tile (set has priority over clear for that bit).
- Duplicate pulses from one PE within a tile are absorbed.
- Pulses after o_tile_count==NUM_TILES are ignored.

Other rules:
- i_start outside IDLE/DONE is ignored.
- Simultaneous i_start and reset: reset wins.

Optional Feature:
SCHED_PERF_CNT_EN:
- Defined: adds outputs o_run_cycles[31:0] (cycles spent in STREAM, saturating) and o_hold_cycles[31:0] (cycles in STREAM with i_stream_hold and issue pending, saturating). Both clear on entry to KLOAD and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package conv_sched_pkg: state encoding (IDLE, KLOAD, KDRAIN, STREAM, DONE), the KE and kernel-bit-width localparams, and the $clog2 width helpers.
- One sub-module: bram_rd_pipe (RD_LATENCY valid shift register plus capture strobe), instantiated twice (kernel, pixel).

Test Plan:
- Reset then i_start, RD_LATENCY=1, kernel BRAMs hold addr+p*32 -> o_kbram_addr 0..26, o_kernel_valid rises 2 cycles after addr 26 issued, PE0 MSB byte=0x00, LSB byte=0x1A.
- STREAM with pixel BRAM data=addr[7:0], no hold -> 300 consecutive o_pixel_valid cycles, first data 0x00 at RD_LATENCY+1 cycles after first addr, last 0x2B; no address beyond 299.
- i_stream_hold high 5 cycles mid-stream (RD_LATENCY=2) -> exactly 2 trailing valid pixels, then a 5-cycle gap; sequence continuous with no loss or duplication.
- i_final_flatten staggered (PE0 t, PE2 t+3, PE1 t+7, PE0 again t+4) -> single o_proc_finish at t+9 (all flags registered t+8), tile_count 0->1.
- All PEs pulse on the clearing edge of tile 1 -> counted toward tile 2. 16 tiles -> o_done=1, o_busy=0; extra pulses leave count at 16.
- reset_n low mid-KDRAIN and mid-STREAM -> all outputs 0 immediately. Next i_start restarts at kbram addr 0.
